// File: rtl/tn20k_vdp_cartridge.sv
// MSX slot front end for the Tang Nano 20K VDP: I/O decode, TMS9918/V9938 port protocol,
// control registers and byte VRAM requests. Optional macro VDP_INTERRUPT_EN enables slot_intr.
module tn20k_vdp_cartridge #(
  parameter logic [7:0] IO_BASE     = 8'h88,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk14m,
  input  logic        slot_reset_n,
  input  logic        slot_iorq_n,
  input  logic        slot_rd_n,
  input  logic        slot_wr_n,
  input  logic [7:0]  slot_a,
  input  logic [7:0]  slot_d_in,
  output logic [7:0]  slot_d_out,
  output logic        slot_data_dir,
  output logic        busdir,
  output logic        slot_wait,
  output logic        slot_intr,
  input  logic        init_done,
  input  logic        vsync_pulse,
  input  logic [6:0]  spr_status,
  output logic        vram_valid,
  output logic        vram_write,
  output logic [16:0] vram_address,
  output logic [7:0]  vram_wdata,
  input  logic        vram_ready,
  input  logic [7:0]  vram_rdata,
  input  logic        vram_rdata_en,
  output logic [71:0] reg_bus
);

  logic [SYNC_STAGES-1:0] iorq_sr, rd_sr, wr_sr, init_sr;

  always_ff @(posedge clk14m or negedge slot_reset_n) begin
    if (!slot_reset_n) begin
      iorq_sr <= '1;
      rd_sr   <= '1;
      wr_sr   <= '1;
      init_sr <= '0;
    end else begin
      iorq_sr[0] <= slot_iorq_n;
      rd_sr[0]   <= slot_rd_n;
      wr_sr[0]   <= slot_wr_n;
      init_sr[0] <= init_done;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        iorq_sr[i] <= iorq_sr[i-1];
        rd_sr[i]   <= rd_sr[i-1];
        wr_sr[i]   <= wr_sr[i-1];
        init_sr[i] <= init_sr[i-1];
      end
    end
  end

  logic iorq_s, rd_s, wr_s, init_s;
  assign iorq_s = iorq_sr[SYNC_STAGES-1];
  assign rd_s   = rd_sr[SYNC_STAGES-1];
  assign wr_s   = wr_sr[SYNC_STAGES-1];
  assign init_s = init_sr[SYNC_STAGES-1];

  logic       addr_hit, bus_act, taken, ev, ev_wr;
  logic [1:0] port;
  assign addr_hit = (slot_a[7:2] == IO_BASE[7:2]);
  assign bus_act  = !iorq_s && (!rd_s || !wr_s) && addr_hit;
  assign port     = slot_a[1:0];
  assign ev_wr    = !wr_s;
  // An access waits for the VRAM request slot to free up; the bus cycle is still live meanwhile.
  assign ev       = bus_act && !taken && !vram_valid;

  logic [7:0][7:0] regs;
  logic [7:0]      r14, latch, rd_ahead;
  logic [13:0]     ptr;
  logic            first, f_flag;
  logic [16:0]     cur_addr, inc_addr, set_addr, set_inc;

  // R#14[2:0] is the top of the 17-bit pointer, so a 17-bit add carries into it for free.
  assign cur_addr = {r14[2:0], ptr};
  assign inc_addr = cur_addr + 17'd1;
  assign set_addr = {r14[2:0], slot_d_in[5:0], latch};
  assign set_inc  = set_addr + 17'd1;

  always_ff @(posedge clk14m or negedge slot_reset_n) begin
    if (!slot_reset_n) begin
      regs         <= '0;
      r14          <= '0;
      latch        <= '0;
      rd_ahead     <= '0;
      ptr          <= '0;
      first        <= 1'b0;
      f_flag       <= 1'b0;
      taken        <= 1'b0;
      slot_d_out   <= '0;
      vram_valid   <= 1'b0;
      vram_write   <= 1'b0;
      vram_address <= '0;
      vram_wdata   <= '0;
    end else begin
      if (vram_valid && vram_ready) vram_valid <= 1'b0;
      if (vram_rdata_en) rd_ahead <= vram_rdata;
      if (iorq_s) taken <= 1'b0;
      if (vsync_pulse) f_flag <= 1'b1;
      else if (ev && port == 2'd1 && !ev_wr) f_flag <= 1'b0;
      if (ev) begin
        taken <= 1'b1;
        case (port)
          2'd0: begin
            first           <= 1'b0;
            vram_valid      <= 1'b1;
            vram_write      <= ev_wr;
            vram_address    <= cur_addr;
            vram_wdata      <= slot_d_in;
            {r14[2:0], ptr} <= inc_addr;
            if (!ev_wr) slot_d_out <= rd_ahead;
          end
          2'd1: begin
            if (!ev_wr) begin
              slot_d_out <= {f_flag, spr_status};
              first      <= 1'b0;
            end else if (!first) begin
              latch <= slot_d_in;
              first <= 1'b1;
            end else begin
              first <= 1'b0;
              if (slot_d_in[7]) begin
                if (slot_d_in[5:3] == 3'b000) regs[slot_d_in[2:0]] <= latch;
                else if (slot_d_in[5:0] == 6'd14) r14 <= latch;
              end else if (slot_d_in[6]) begin
                {r14[2:0], ptr} <= set_addr;
              end else begin
                vram_valid      <= 1'b1;
                vram_write      <= 1'b0;
                vram_address    <= set_addr;
                {r14[2:0], ptr} <= set_inc;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign slot_data_dir = !iorq_s && !rd_s && addr_hit && !slot_a[1];
  assign busdir        = slot_data_dir;
  assign slot_wait     = !init_s || (bus_act && port == 2'd0 && vram_valid);
  assign reg_bus       = {r14, regs};

`ifdef VDP_INTERRUPT_EN
  assign slot_intr = f_flag & regs[1][5];
`else
  assign slot_intr = 1'b0;
`endif

endmodule

// File: tb/tb_tn20k_vdp_cartridge.sv
// Bench for tn20k_vdp_cartridge: table-driven register writes, hand sequences for wait/carry/status/reset,
// and a randomized run checked against a port-level model of the VDP with its own VRAM image.
module tb_tn20k_vdp_cartridge;
  localparam logic [7:0] BASE = 8'h88;
  localparam int SYNC = 2;

  logic        clk14m, slot_reset_n, slot_iorq_n, slot_rd_n, slot_wr_n;
  logic [7:0]  slot_a, slot_d_in, slot_d_out;
  logic        slot_data_dir, busdir, slot_wait, slot_intr, init_done, vsync_pulse;
  logic [6:0]  spr_status;
  logic        vram_valid, vram_write, vram_ready, vram_rdata_en;
  logic [16:0] vram_address;
  logic [7:0]  vram_wdata, vram_rdata;
  logic [71:0] reg_bus;

  tn20k_vdp_cartridge #(.IO_BASE(BASE), .SYNC_STAGES(SYNC)) dut (
    .clk14m(clk14m), .slot_reset_n(slot_reset_n), .slot_iorq_n(slot_iorq_n), .slot_rd_n(slot_rd_n),
    .slot_wr_n(slot_wr_n), .slot_a(slot_a), .slot_d_in(slot_d_in), .slot_d_out(slot_d_out),
    .slot_data_dir(slot_data_dir), .busdir(busdir), .slot_wait(slot_wait), .slot_intr(slot_intr),
    .init_done(init_done), .vsync_pulse(vsync_pulse), .spr_status(spr_status),
    .vram_valid(vram_valid), .vram_write(vram_write), .vram_address(vram_address),
    .vram_wdata(vram_wdata), .vram_ready(vram_ready), .vram_rdata(vram_rdata),
    .vram_rdata_en(vram_rdata_en), .reg_bus(reg_bus));

  initial clk14m = 1'b0;
  always #5 clk14m = ~clk14m;

  typedef struct {logic w; logic [16:0] a; logic [7:0] d;} vreq_t;
  typedef struct {logic [7:0] b0; logic [7:0] b1; int idx; logic [7:0] val;} regvec_t;

  vreq_t got_q[$], acc_q[$], exp_q[$];
  logic [7:0] vmem[int];
  logic [7:0] mmem[int];
  bit stall;
  int checks = 0, errors = 0;
  logic [16:0] last_addr;

  // Model state: the 17-bit VRAM pointer kept as a plain integer.
  int m_addr;
  logic [7:0] m_regs[8];
  logic [7:0] m_r14, m_latch, m_ra;
  bit m_first, m_f;

  always @(posedge clk14m) begin
    if (slot_reset_n && vram_valid && vram_ready) begin
      got_q.push_back('{vram_write, vram_address, vram_wdata});
      acc_q.push_back('{vram_write, vram_address, vram_wdata});
    end
  end

  initial begin
    vreq_t r;
    vram_ready = 1'b0; vram_rdata_en = 1'b0; vram_rdata = 8'h00;
    forever begin
      @(negedge clk14m);
      vram_rdata_en = 1'b0;
      while (acc_q.size() > 0) begin
        r = acc_q.pop_front();
        if (r.w) vmem[int'(r.a)] = r.d;
        else begin
          vram_rdata = vmem.exists(int'(r.a)) ? vmem[int'(r.a)] : 8'h00;
          vram_rdata_en = 1'b1;
        end
      end
      vram_ready = vram_valid && !stall && ($urandom_range(0, 2) != 0);
    end
  end

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] rd_mem(input int a);
    return mmem.exists(a) ? mmem[a] : 8'h00;
  endfunction

  function automatic logic [71:0] exp_bus();
    logic [71:0] r;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = m_regs[i];
    r[71:64] = {m_r14[7:3], 3'(m_addr / 16384)};
    return r;
  endfunction

  function automatic logic exp_intr();
`ifdef VDP_INTERRUPT_EN
    return m_f & m_regs[1][5];
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_addr = 0; m_r14 = 0; m_latch = 0; m_ra = 0; m_first = 0; m_f = 0;
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    exp_q.delete();
  endtask

  task automatic prefetch();
    vreq_t e;
    e.w = 1'b0; e.a = 17'(m_addr); e.d = 8'h00;
    exp_q.push_back(e);
    m_ra = rd_mem(m_addr);
    m_addr = (m_addr + 1) % 131072;
  endtask

  task automatic model_write(input logic [1:0] p, input logic [7:0] d);
    vreq_t e;
    if (p == 2'd0) begin
      e.w = 1'b1; e.a = 17'(m_addr); e.d = d;
      exp_q.push_back(e);
      mmem[m_addr] = d;
      m_addr = (m_addr + 1) % 131072;
      m_first = 0;
    end else if (p == 2'd1) begin
      if (!m_first) begin
        m_latch = d; m_first = 1;
      end else begin
        m_first = 0;
        if (d[7]) begin
          if (int'(d[5:0]) < 8) m_regs[d[2:0]] = m_latch;
          else if (d[5:0] == 6'd14) begin
            m_r14 = m_latch;
            m_addr = int'(m_latch[2:0]) * 16384 + m_addr % 16384;
          end
        end else begin
          m_addr = (m_addr / 16384) * 16384 + int'(d[5:0]) * 256 + int'(m_latch);
          if (!d[6]) prefetch();
        end
      end
    end
  endtask

  task automatic model_read(input logic [1:0] p, output logic [7:0] r);
    r = 8'h00;
    if (p == 2'd0) begin
      r = m_ra; prefetch(); m_first = 0;
    end else if (p == 2'd1) begin
      r = {m_f, spr_status}; m_f = 0; m_first = 0;
    end
  endtask

  task automatic drain();
    vreq_t g, e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("vram_req_missing", got_q.size() == 0, 0);
      if (got_q.size() > 0) begin
        g = got_q.pop_front();
        chk("vram_write", g.w, e.w);
        chk("vram_address", g.a, e.a);
        if (e.w) chk("vram_wdata", g.d, e.d);
        last_addr = g.a;
      end
    end
    chk("vram_req_extra", got_q.size(), 0);
    got_q.delete();
  endtask

  task automatic post_chk();
    chk("reg_bus", reg_bus, exp_bus());
    chk("slot_intr", slot_intr, exp_intr());
  endtask

  task automatic bus_cycle(input logic [7:0] a, input bit wr, input logic [7:0] d,
                           input int stall_cyc, output logic [7:0] q);
    int n;
    bit own;
    own = (a[7:2] == BASE[7:2]);
    @(negedge clk14m);
    slot_a = a; slot_d_in = d; slot_iorq_n = 1'b0; slot_wr_n = !wr; slot_rd_n = wr;
    if (stall_cyc > 0) begin
      stall = 1'b1;
      repeat (SYNC + 3 + stall_cyc) @(negedge clk14m);
      chk("wait_stalled", slot_wait, 1);
      chk("addr_stalled", vram_address, 17'(m_addr));
      stall = 1'b0;
    end
    repeat (SYNC + 2) @(negedge clk14m);
    n = 0;
    while ((slot_wait || vram_valid) && n < 500) begin
      @(negedge clk14m);
      n++;
    end
    chk("bus_timeout", n >= 500, 0);
    repeat (2) @(negedge clk14m);
    q = slot_d_out;
    chk("data_dir", slot_data_dir, own && !wr && !a[1]);
    chk("busdir", busdir, own && !wr && !a[1]);
    slot_iorq_n = 1'b1; slot_rd_n = 1'b1; slot_wr_n = 1'b1;
    repeat (SYNC + 3) @(negedge clk14m);
  endtask

  task automatic io_wr(input logic [7:0] a, input logic [7:0] d, input int stall_cyc);
    logic [7:0] q;
    bus_cycle(a, 1'b1, d, stall_cyc, q);
    if (a[7:2] == BASE[7:2]) model_write(a[1:0], d);
    drain();
    post_chk();
  endtask

  task automatic io_rd(input logic [7:0] a, output logic [7:0] q);
    logic [7:0] e;
    bus_cycle(a, 1'b0, 8'h00, 0, q);
    if (a[7:2] == BASE[7:2]) begin
      model_read(a[1:0], e);
      if (!a[1]) chk("read_data", q, e);
    end
    drain();
    post_chk();
  endtask

  task automatic vsync();
    @(negedge clk14m); vsync_pulse = 1'b1;
    @(negedge clk14m); vsync_pulse = 1'b0;
    m_f = 1;
    chk("intr_after_vsync", slot_intr, exp_intr());
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    regvec_t tbl[10];
    logic [7:0] nt[8];
    logic [7:0] q;
    logic [71:0] rb;
    int n;

    tbl[0] = '{8'h00, 8'h80, 0, 8'h00}; tbl[1] = '{8'h43, 8'h81, 1, 8'h43};
    tbl[2] = '{8'h06, 8'h82, 2, 8'h06}; tbl[3] = '{8'h80, 8'h83, 3, 8'h80};
    tbl[4] = '{8'h00, 8'h84, 4, 8'h00}; tbl[5] = '{8'h36, 8'h85, 5, 8'h36};
    tbl[6] = '{8'h07, 8'h86, 6, 8'h07}; tbl[7] = '{8'hF4, 8'h87, 7, 8'hF4};
    tbl[8] = '{8'h55, 8'h89, 1, 8'h43}; tbl[9] = '{8'hF0, 8'h8E, 8, 8'hF0};
    nt[0] = 8'd0; nt[1] = 8'd0; nt[2] = 8'd4; nt[3] = 8'd12;
    nt[4] = 8'd208; nt[5] = 8'd208; nt[6] = 8'd208; nt[7] = 8'd208;

    slot_reset_n = 1'b0; slot_iorq_n = 1'b1; slot_rd_n = 1'b1; slot_wr_n = 1'b1;
    slot_a = 8'h00; slot_d_in = 8'h00; init_done = 1'b0; vsync_pulse = 1'b0;
    spr_status = 7'h00; stall = 1'b0;
    model_reset();
    repeat (3) @(negedge clk14m);
    chk("rst_wait", slot_wait, 1);
    chk("rst_d_out", slot_d_out, 8'h00);
    chk("rst_dir", slot_data_dir, 0);
    chk("rst_busdir", busdir, 0);
    chk("rst_intr", slot_intr, 0);
    chk("rst_vram_valid", vram_valid, 0);
    chk("rst_reg_bus", reg_bus, 72'h0);
    slot_reset_n = 1'b1;
    repeat (5) @(negedge clk14m);
    chk("wait_no_init", slot_wait, 1);
    init_done = 1'b1;
    repeat (SYNC + 1) @(negedge clk14m);
    chk("wait_init_done", slot_wait, 0);

    // Register writes through the two-byte control protocol.
    for (int i = 0; i < 10; i++) begin
      io_wr(8'h89, tbl[i].b0, 0);
      io_wr(8'h89, tbl[i].b1, 0);
      rb = reg_bus;
      chk($sformatf("regvec%0d", i), rb[tbl[i].idx*8 +: 8], tbl[i].val);
    end

    // Sequential writes from 0, then across the 0x3FFF boundary into R#14.
    io_wr(8'h89, 8'h00, 0); io_wr(8'h89, 8'h40, 0);
    for (int i = 0; i < 8; i++) io_wr(8'h88, 8'(i), 0);
    chk("seq_last_addr", last_addr, 17'h00007);
    io_wr(8'h89, 8'h00, 0); io_wr(8'h89, 8'h7F, 0);
    for (int i = 0; i < 256; i++) io_wr(8'h88, 8'(i), 0);
    chk("pre_carry_addr", last_addr, 17'h03FFF);
    chk("r14_carry", reg_bus[71:64], 8'hF1);
    io_wr(8'h88, 8'hAB, 0);
    chk("carry_addr", last_addr, 17'h04000);
    io_wr(8'h89, 8'h07, 0); io_wr(8'h89, 8'h8E, 0);
    io_wr(8'h89, 8'hFF, 0); io_wr(8'h89, 8'h7F, 0);
    io_wr(8'h88, 8'h11, 0);
    chk("top_addr", last_addr, 17'h1FFFF);
    io_wr(8'h88, 8'h22, 0);
    chk("wrap_addr", last_addr, 17'h00000);
    chk("r14_wrap", reg_bus[71:64], 8'h00);

    // Name-table bytes with one write held off by the SDRAM side.
    io_wr(8'h89, 8'h00, 0); io_wr(8'h89, 8'h5B, 0);
    for (int i = 0; i < 8; i++) io_wr(8'h88, nt[i], (i == 2) ? 30 : 0);
    chk("nt_last_addr", last_addr, 17'h01B07);
    io_wr(8'h89, 8'h00, 0); io_wr(8'h89, 8'h1B, 0);
    for (int i = 0; i < 8; i++) begin
      io_rd(8'h88, q);
      chk($sformatf("nt_read%0d", i), q, nt[i]);
    end

    io_wr(8'h89, 8'h00, 0); io_wr(8'h89, 8'h78, 0);
    for (int i = 0; i < 96; i++) io_wr(8'h88, (i < 32) ? 8'hFF : (i < 64) ? 8'hAA : 8'h55, 0);
    chk("pat_last_addr", last_addr, 17'h0385F);
    io_wr(8'h89, 8'h20, 0); io_wr(8'h89, 8'h38, 0);
    io_rd(8'h88, q);
    chk("pat_read", q, 8'hAA);

    // Status flag and interrupt enable.
    spr_status = 7'h15;
    vsync();
    chk("intr_ie0", slot_intr, 0);
    io_rd(8'h89, q);
    chk("status_f_set", q, 8'h95);
    io_rd(8'h89, q);
    chk("status_f_clr", q[7], 0);
    io_wr(8'h89, 8'h63, 0); io_wr(8'h89, 8'h81, 0);
    vsync();
`ifdef VDP_INTERRUPT_EN
    chk("intr_ie1", slot_intr, 1);
`else
    chk("intr_ie1", slot_intr, 0);
`endif
    io_rd(8'h89, q);
    chk("intr_cleared", slot_intr, 0);
    io_wr(8'h89, 8'h43, 0); io_wr(8'h89, 8'h81, 0);
    @(negedge clk14m); vsync_pulse = 1'b1; m_f = 1;
    io_rd(8'h89, q);
    chk("status_vs_hold", q[7], 1);
    @(negedge clk14m); vsync_pulse = 1'b0; m_f = 1;
    io_rd(8'h89, q);
    chk("vsync_set_wins", q[7], 1);
    io_rd(8'h89, q);
    chk("status_after", q[7], 0);

    // Randomized port traffic against the model.
    for (int it = 0; it < 400; it++) begin
      spr_status = 7'($urandom);
      case ($urandom_range(0, 9))
        0, 1, 2: io_wr(8'h88, 8'($urandom), 0);
        3, 4: io_rd(8'h88, q);
        5: begin
          io_wr(8'h89, 8'($urandom), 0);
          io_wr(8'h89, {1'b0, 1'($urandom), 6'($urandom)}, 0);
        end
        6: begin
          n = $urandom_range(0, 3);
          io_wr(8'h89, 8'($urandom), 0);
          io_wr(8'h89, {2'b10, (n == 0) ? 6'd14 : (n == 1) ? 6'($urandom) : {3'b000, 3'($urandom)}}, 0);
        end
        7: io_rd(8'h89, q);
        8: io_wr(8'h89, 8'($urandom), 0);
        default: begin
          n = $urandom_range(0, 3);
          if (n == 0) io_wr(8'h8A, 8'($urandom), 0);
          else if (n == 1) io_rd(8'h8B, q);
          else if (n == 2) io_wr(8'h98, 8'($urandom), 0);
          else io_rd(8'h8C, q);
        end
      endcase
      if ($urandom_range(0, 7) == 0) vsync();
    end

    // Reset while a VRAM write is waiting for acceptance.
    stall = 1'b1;
    @(negedge clk14m);
    slot_a = 8'h88; slot_d_in = 8'h5A; slot_iorq_n = 1'b0; slot_wr_n = 1'b0;
    n = 0;
    while (!vram_valid && n < 50) begin
      @(negedge clk14m);
      n++;
    end
    chk("rst_mid_pending", vram_valid, 1);
    slot_reset_n = 1'b0;
    #1;
    chk("rst_mid_valid", vram_valid, 0);
    chk("rst_mid_reg_bus", reg_bus, 72'h0);
    chk("rst_mid_wait", slot_wait, 1);
    chk("rst_mid_d_out", slot_d_out, 8'h00);
    @(negedge clk14m);
    slot_iorq_n = 1'b1; slot_wr_n = 1'b1; stall = 1'b0;
    repeat (3) @(negedge clk14m);
    slot_reset_n = 1'b1;
    model_reset();
    repeat (SYNC + 2) @(negedge clk14m);
    chk("wait_after_rst", slot_wait, 0);
    drain();
    io_wr(8'h89, 8'h00, 0); io_wr(8'h89, 8'h40, 0);
    io_wr(8'h88, 8'h77, 0);
    chk("post_rst_addr", last_addr, 17'h00000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
